rand_gen_lfsr: RTL
==================

Name: rand_gen_lfsr

Overview:
Parametrised successor to the 8-bit rand_gen: a WIDTH-bit Fibonacci LFSR with a configurable tap mask and a zero-lock guard. It adds a post-seed warm-up phase and a valid/ready handshake so consumers, such as neuron spike-injection logic, take exactly one fresh value per transfer. An optional Bernoulli comparator turns each value into a stochastic spike.

Parameters:
WIDTH, 8, LFSR and output width (≥3).
TAPS, 8'hB8, feedback mask over state bits; default is x^8+x^6+x^5+x^4+1, maximal length 255.
DEFAULT_SEED, 1, nonzero state used at reset and whenever a zero seed is loaded.
WARMUP, 4, LFSR steps discarded after reset/seed load before valid_o rises (0..255).

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous reset, active-high
seed_i  input  WIDTH  seed value
set_seed_i  input  1  load seed_i this cycle
en_i  input  1  global advance enable
ready_i  input  1  consumer accepts rand_o
rand_o  output  WIDTH  current LFSR state
valid_o  output  1  rand_o is a post-warm-up value
prob_i  input  WIDTH  spike probability threshold (RAND_GEN_SPIKE_EN only)
spike_o  output  1  Bernoulli spike (RAND_GEN_SPIKE_EN only)

Behaviour:
- Step function: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}. State is never 0.
- Reset (async, any time): state=DEFAULT_SEED, FSM=WARMUP, warm counter=0, valid_o=0, spike_o=0.
- FSM WARMUP, valid_o=0:
  - if en_i: step and increment counter.
  - the edge performing step WARMUP moves to RUN, so valid_o=1 and rand_o = DEFAULT_SEED stepped WARMUP times.
  - en_i=0 freezes state and counter.
- FSM RUN, valid_o=1: step only on an edge where en_i && ready_i. Otherwise rand_o holds stable.
- set_seed_i has priority over stepping, in any state:
  - state = seed_i, or DEFAULT_SEED if seed_i==0.
  - counter=0; FSM=WARMUP, so valid_o=0 next cycle.
  - set_seed_i held high reloads every cycle and valid_o stays 0.
- WARMUP=0: reset and seed load enter RUN directly; valid_o=1 on the first cycle after, with rand_o = the loaded value.
- Period: with maximal TAPS, rand_o repeats after 2^WIDTH-1 accepted steps; wrap-around is natural.
- ready_i is ignored while valid_o=0.
- No combinational path from ready_i to rand_o or valid_o.

Optional Feature:
Macro RAND_GEN_SPIKE_EN.
- Defined: prob_i and spike_o exist; spike_o = valid_o && (rand_o < prob_i), combinational from registered rand_o. prob_i=0 never spikes.
- Undefined: prob_i and spike_o ports and the comparator are absent; the rest of the behaviour is identical.

Test Plan:
1. Defaults, reset then en_i=1, ready_i=0 -> valid_o=0 for 4 cycles, then valid_o=1, rand_o=8'h11, held while ready_i=0.
2. From RUN at 8'h11, ready_i=1 for 2 cycles -> rand_o 8'h23 then 8'h47; en_i=0 with ready_i=1 -> rand_o frozen.
3. set_seed_i pulse with seed_i=8'h00 -> state 8'h01, valid_o=0 next cycle, valid again after 4 steps with 8'h11. Set_seed during RUN with ready_i=1 -> load wins and no step occurs.
4. Continuous accept from 8'h01 -> 255 distinct nonzero values, then 8'h01 recurs at step 255.
5. Assert rst mid-warm-up and mid-RUN asynchronously -> outputs return to reset values immediately, without waiting for a clock edge.
6. RAND_GEN_SPIKE_EN, accept 255 values with prob_i=8'h80 -> exactly 127 spikes. prob_i=8'h00 -> 0 spikes; prob_i=8'hFF -> 254 spikes.

Source files
------------

// File: rtl/rand_gen_lfsr.sv
// WIDTH-bit Fibonacci LFSR random source with post-seed warm-up and a valid/ready handshake.
// Define RAND_GEN_SPIKE_EN to add the prob_i/spike_o Bernoulli spike comparator.
module rand_gen_lfsr #(
   parameter int unsigned       WIDTH        = 8,
   parameter logic [WIDTH-1:0]  TAPS         = 'hB8,
   parameter logic [WIDTH-1:0]  DEFAULT_SEED = 'd1,
   parameter int unsigned       WARMUP       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] seed_i,
   input  logic             set_seed_i,
   input  logic             en_i,
   input  logic             ready_i,
   output logic [WIDTH-1:0] rand_o,
   output logic             valid_o
`ifdef RAND_GEN_SPIKE_EN
   ,
   input  logic [WIDTH-1:0] prob_i,
   output logic             spike_o
`endif
);

   localparam logic [0:0] ST_WARMUP = 1'b0;
   localparam logic [0:0] ST_RUN    = 1'b1;

   // With no warm-up, a reset or seed load lands straight in RUN.
   localparam logic [0:0] ST_AFTER_LOAD = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
   localparam logic [7:0] WARM_LAST     = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

   logic [WIDTH-1:0] lfsr_state;
   logic [WIDTH-1:0] lfsr_next;
   logic [WIDTH-1:0] load_value;
   logic [7:0]       warm_cnt;
   logic [0:0]       fsm_state;
   logic             feedback;

   always_comb begin
      feedback   = ^(lfsr_state & TAPS);
      lfsr_next  = {lfsr_state[WIDTH-2:0], feedback};
      load_value = (seed_i == '0) ? DEFAULT_SEED : seed_i;
   end

   // A seed load wins over any step; otherwise warm-up steps on en_i alone and RUN needs a transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_state <= DEFAULT_SEED;
         warm_cnt   <= 8'd0;
         fsm_state  <= ST_AFTER_LOAD;
      end else if (set_seed_i) begin
         lfsr_state <= load_value;
         warm_cnt   <= 8'd0;
         fsm_state  <= ST_AFTER_LOAD;
      end else if (fsm_state == ST_WARMUP) begin
         if (en_i) begin
            lfsr_state <= lfsr_next;
            warm_cnt   <= warm_cnt + 8'd1;
            if (warm_cnt == WARM_LAST) begin
               fsm_state <= ST_RUN;
            end
         end
      end else begin
         if (en_i && ready_i) begin
            lfsr_state <= lfsr_next;
         end
      end
   end

   assign rand_o  = lfsr_state;
   assign valid_o = (fsm_state == ST_RUN);

`ifdef RAND_GEN_SPIKE_EN
   assign spike_o = valid_o && (lfsr_state < prob_i);
`endif

endmodule
